// File: rtl/rr_demux_dispatch.sv
// rr_demux_dispatch
// Round-robin dispatcher feeding a 1:4 demultiplexer. Words arrive on a
// valid/ready handshake. Each word is given to the next enabled channel in
// round-robin order and held in a one-entry output register. The held word
// and its 2-bit channel select drive the demux until that channel accepts it.
// A saturating counter records completed transfers.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  upstream word valid
//   in_data   upstream word (DATA_W bits)
//   in_ready  block can accept a word this cycle
//   en_mask   per-channel enable, bit i allows channel i
//   ch_ready  per-channel sink ready, bit i applies to channel i
//   out_valid held word valid toward the demux
//   out_data  held word, drives demux data input
//   out_sel   channel index, drives demux select
//   xfer_cnt  completed transfers, saturating at all-ones
module rr_demux_dispatch #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [3:0]        en_mask,
    input  logic [3:0]        ch_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    output logic [CNT_W-1:0]  xfer_cnt
);

    logic              r_outValid;
    logic [DATA_W-1:0] r_outData;
    logic [1:0]        r_outSel;
    logic [1:0]        r_ptr;
    logic [CNT_W-1:0]  r_xferCnt;

    logic       w_xfer;
    logic       w_acc;
    logic       w_inReady;
    logic [1:0] w_pickSel;
    logic [1:0] w_cand;
    logic       w_found;

    // Only the addressed channel's ready matters; other channels are ignored.
    assign w_xfer    = r_outValid & ch_ready[r_outSel];

    // The register can be refilled in the same cycle its word leaves, so a
    // ready sink sees one word per cycle with no bubbles.
    assign w_inReady = (en_mask != 4'b0000) & (~r_outValid | w_xfer);
    assign w_acc     = in_valid & w_inReady;

    // Search the enabled channels starting from the round-robin pointer.
    // The 2-bit add wraps naturally from 3 back to 0. When the mask is empty
    // nothing is accepted, so the fallback value is never loaded.
    always_comb begin
        w_pickSel = r_ptr;
        w_cand    = r_ptr;
        w_found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && en_mask[w_cand]) begin
                w_pickSel = w_cand;
                w_found   = 1'b1;
            end
        end
    end

    // Output register and pointer. A new accept takes priority over a drain,
    // so back-to-back words keep out_valid high. On a drain with no new word,
    // data and select hold their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outSel   <= 2'd0;
            r_ptr      <= 2'd0;
        end else if (w_acc) begin
            r_outValid <= 1'b1;
            r_outData  <= in_data;
            r_outSel   <= w_pickSel;
            r_ptr      <= w_pickSel + 2'd1;
        end else if (w_xfer) begin
            r_outValid <= 1'b0;
        end
    end

    // The transfer counter stops at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xferCnt <= '0;
        end else if (w_xfer && (r_xferCnt != {CNT_W{1'b1}})) begin
            r_xferCnt <= r_xferCnt + CNT_W'(1);
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_sel   = r_outSel;
    assign xfer_cnt  = r_xferCnt;

endmodule

// File: tb/tb_rr_demux_dispatch.sv
// tb_rr_demux_dispatch
// Directed bench for rr_demux_dispatch. Two instances share the same stimulus:
// one with the default 8-bit counter and one with a 3-bit counter so that
// saturation is reached. A behavioural model of the dispatcher runs alongside
// and is compared against both instances every cycle. Literal expectations at
// key points pin the model itself.
module tb_rr_demux_dispatch;

    logic       clk;
    logic       rstN;
    logic       inValid;
    logic [0:0] inData;
    logic [3:0] enMask;
    logic [3:0] chReady;

    logic       inReady,  outValid;
    logic [0:0] outData;
    logic [1:0] outSel;
    logic [7:0] xferCnt;

    logic       inReadyS, outValidS;
    logic [0:0] outDataS;
    logic [1:0] outSelS;
    logic [2:0] xferCntS;

    int checks   = 0;
    int failures = 0;

    rr_demux_dispatch #(.DATA_W(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_data(inData),
        .in_ready(inReady), .en_mask(enMask), .ch_ready(chReady),
        .out_valid(outValid), .out_data(outData), .out_sel(outSel),
        .xfer_cnt(xferCnt)
    );

    rr_demux_dispatch #(.DATA_W(1), .CNT_W(3)) dutSat (
        .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_data(inData),
        .in_ready(inReadyS), .en_mask(enMask), .ch_ready(chReady),
        .out_valid(outValidS), .out_data(outDataS), .out_sel(outSelS),
        .xfer_cnt(xferCntS)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a single held slot, a round-robin pointer kept as a
    // plain integer, and a counter capped at a given maximum.
    typedef struct packed {
        bit valid;
        bit data;
        int sel;
        int ptr;
        int cnt;
    } ModelT;

    ModelT mBig, mSat;
    localparam ModelT MODEL_RESET = '{valid: 1'b0, data: 1'b0, sel: 0, ptr: 0, cnt: 0};

    function automatic bit modelReady(ModelT m, logic [3:0] en, logic [3:0] rdy);
        return (en != 4'b0000) && (!m.valid || rdy[m.sel]);
    endfunction

    function automatic ModelT modelNext(ModelT m, int maxCnt, logic v, logic d,
                                        logic [3:0] en, logic [3:0] rdy);
        ModelT n;
        bit    leaving;
        bit    taking;
        n       = m;
        leaving = m.valid && rdy[m.sel];
        taking  = v && modelReady(m, en, rdy);
        if (taking) begin
            for (int k = 0; k < 4; k++) begin
                if (en[(m.ptr + k) % 4]) begin
                    n.sel = (m.ptr + k) % 4;
                    break;
                end
            end
            n.ptr   = (n.sel + 1) % 4;
            n.data  = d;
            n.valid = 1'b1;
        end else if (leaving) begin
            n.valid = 1'b0;
        end
        if (leaving && m.cnt < maxCnt) n.cnt = m.cnt + 1;
        return n;
    endfunction

    // Model state advances on the same edges as the DUT, including the
    // asynchronous reset.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mBig <= MODEL_RESET;
            mSat <= MODEL_RESET;
        end else begin
            mBig <= modelNext(mBig, 255, inValid, inData[0], enMask, chReady);
            mSat <= modelNext(mSat, 7,   inValid, inData[0], enMask, chReady);
        end
    end

    // Single comparison helper; every check in the bench goes through here.
    task automatic check(string name, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Compare both instances against the model, mid-cycle on every falling edge.
    task automatic checkOutput();
        check("in_ready",    int'(inReady),    int'(modelReady(mBig, enMask, chReady)));
        check("out_valid",   int'(outValid),   int'(mBig.valid));
        check("out_data",    int'(outData),    int'(mBig.data));
        check("out_sel",     int'(outSel),     mBig.sel);
        check("xfer_cnt",    int'(xferCnt),    mBig.cnt);
        check("s_in_ready",  int'(inReadyS),   int'(modelReady(mSat, enMask, chReady)));
        check("s_out_valid", int'(outValidS),  int'(mSat.valid));
        check("s_out_data",  int'(outDataS),   int'(mSat.data));
        check("s_out_sel",   int'(outSelS),    mSat.sel);
        check("s_xfer_cnt",  int'(xferCntS),   mSat.cnt);
    endtask

    always @(negedge clk) checkOutput();

    // Set inputs, let one rising edge pass, and return just after it.
    task automatic applyStimulus(logic v, logic d, logic [3:0] en, logic [3:0] rdy);
        inValid = v;
        inData  = d;
        enMask  = en;
        chReady = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN    = 1'b0;
        inValid = 1'b0;
        inData  = 1'b0;
        enMask  = 4'b0000;
        chReady = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(outValid), 0);
        check("reset_xfer_cnt",  int'(xferCnt),  0);
        #3 rstN = 1'b1;

        // Streaming on all channels: selects 0,1,2,3,0 one cycle behind input.
        $display("[TB] stream on all channels");
        applyStimulus(1, 1, 4'b1111, 4'b1111);
        check("t1_sel0", int'(outSel), 0);
        check("t1_data0", int'(outData), 1);
        applyStimulus(1, 0, 4'b1111, 4'b1111);
        check("t1_sel1", int'(outSel), 1);
        applyStimulus(1, 1, 4'b1111, 4'b1111);
        check("t1_sel2", int'(outSel), 2);
        applyStimulus(1, 1, 4'b1111, 4'b1111);
        check("t1_sel3", int'(outSel), 3);
        applyStimulus(1, 0, 4'b1111, 4'b1111);
        check("t1_sel4_wrap", int'(outSel), 0);
        applyStimulus(0, 0, 4'b1111, 4'b1111);
        check("t1_cnt5", int'(xferCnt), 5);
        check("t1_drained", int'(outValid), 0);

        // Channels 0 and 2 disabled: selects alternate 1,3,1,3.
        $display("[TB] skip disabled channels");
        applyStimulus(1, 1, 4'b1010, 4'b1111);
        check("t2_sel_a", int'(outSel), 1);
        applyStimulus(1, 0, 4'b1010, 4'b1111);
        check("t2_sel_b", int'(outSel), 3);
        applyStimulus(1, 1, 4'b1010, 4'b1111);
        check("t2_sel_c", int'(outSel), 1);
        applyStimulus(1, 0, 4'b1010, 4'b1111);
        check("t2_sel_d", int'(outSel), 3);
        applyStimulus(0, 0, 4'b1010, 4'b1111);
        check("t2_cnt9", int'(xferCnt), 9);
        check("t2_sat_cnt7", int'(xferCntS), 7);

        // Backpressure on channel 0 for three cycles, then same-cycle refill.
        $display("[TB] backpressure");
        applyStimulus(1, 1, 4'b1111, 4'b1110);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 4'b1111, 4'b1110);
            check("t3_hold_valid", int'(outValid), 1);
            check("t3_hold_sel",   int'(outSel),   0);
            check("t3_hold_data",  int'(outData),  1);
            check("t3_hold_ready", int'(inReady),  0);
        end
        chReady = 4'b1111;
        #1;
        check("t3_ready_on_drain", int'(inReady), 1);
        applyStimulus(1, 0, 4'b1111, 4'b1111);
        check("t3_next_sel",   int'(outSel),   1);
        check("t3_next_data",  int'(outData),  0);
        check("t3_next_valid", int'(outValid), 1);
        applyStimulus(0, 0, 4'b1111, 4'b1111);
        check("t3_cnt11", int'(xferCnt), 11);

        // Hold on channel 2, empty the mask, drain, then restore only channel 0.
        $display("[TB] mask change while holding");
        applyStimulus(1, 1, 4'b1111, 4'b1011);
        check("t4_hold_sel2", int'(outSel), 2);
        applyStimulus(0, 0, 4'b0000, 4'b1011);
        check("t4_still_sel2",   int'(outSel),   2);
        check("t4_still_valid",  int'(outValid), 1);
        applyStimulus(1, 0, 4'b0000, 4'b1111);
        check("t4_drained",      int'(outValid), 0);
        check("t4_empty_ready",  int'(inReady),  0);
        applyStimulus(1, 0, 4'b0000, 4'b1111);
        check("t4_no_accept",    int'(outValid), 0);
        applyStimulus(1, 1, 4'b0001, 4'b1111);
        check("t4_wrap_sel0",    int'(outSel),   0);
        check("t4_wrap_valid",   int'(outValid), 1);
        applyStimulus(0, 0, 4'b0001, 4'b1111);
        check("t4_cnt13", int'(xferCnt), 13);

        // Asynchronous reset while a word is held.
        $display("[TB] reset mid-transfer");
        applyStimulus(1, 1, 4'b1111, 4'b0000);
        applyStimulus(0, 0, 4'b1111, 4'b0000);
        check("t5_pre_valid", int'(outValid), 1);
        #2 rstN = 1'b0;
        #1;
        check("t5_rst_valid", int'(outValid), 0);
        check("t5_rst_data",  int'(outData),  0);
        check("t5_rst_sel",   int'(outSel),   0);
        check("t5_rst_cnt",   int'(xferCnt),  0);
        check("t5_rst_scnt",  int'(xferCntS), 0);
        @(posedge clk);
        #2 rstN = 1'b1;
        applyStimulus(1, 1, 4'b1111, 4'b1111);
        check("t5_first_sel0", int'(outSel), 0);

        // Ten more words streaming, counter of the narrow instance stops at 7.
        $display("[TB] counter saturation");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1'(i), 4'b1111, 4'b1111);
        end
        applyStimulus(0, 0, 4'b1111, 4'b1111);
        check("t5_cnt11",      int'(xferCnt),  11);
        check("t5_sat_cnt7",   int'(xferCntS), 7);
        applyStimulus(0, 0, 4'b1111, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_demux_dispatch.md
Name: rr_demux_dispatch

Overview:
- Round-robin dispatcher that sits directly upstream of the 1:4 demultiplexer.
- Accepts a word stream over a valid/ready handshake and assigns each word to one of four output channels in round-robin order, skipping disabled channels.
- Holds the word in a one-entry output register and presents the registered data and 2-bit channel select to the demux data/select inputs until the addressed channel accepts it.
- Keeps a saturating count of completed transfers.

Parameters:
DATA_W, 1, width of data word (1 matches demux single-bit data input)
CNT_W, 8, width of saturating transfer counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_data  input  DATA_W  upstream word
in_ready  output  1  block can accept word this cycle
en_mask  input  4  per-channel enable; bit i=1 allows channel i
ch_ready  input  4  per-channel sink ready; bit i applies to channel i
out_valid  output  1  held word valid toward demux
out_data  output  DATA_W  held word; drives demux data input
out_sel  output  2  channel index; drives demux select
xfer_cnt  output  CNT_W  completed transfers, saturating

Behaviour:
- Single clock domain. Reset is asynchronous, active-low, on rst_n.
- Reset values: out_valid=0, out_data=0, out_sel=0, xfer_cnt=0, internal pointer ptr=0. in_ready is combinational from these values.
- Output transfer: xfer = out_valid & ch_ready[out_sel].
- Input accept: acc = in_valid & in_ready.
- in_ready = (en_mask != 0) & (!out_valid | xfer). This permits back-to-back accept in the same cycle a held word leaves.
- Channel pick on acc:
  - sel = first index i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with en_mask[i]=1.
  - Next cycle: out_sel<=sel, out_data<=in_data, out_valid<=1, ptr<=(sel+1) mod 4. The 3->0 wrap is required.
- On xfer without acc: out_valid<=0. out_data and out_sel keep their last values.
- On xfer and acc in the same cycle: the new word loads and out_valid stays 1.
- Latency: word accepted at edge N is presented at out_* after edge N (one cycle). It completes at the first later edge where ch_ready[out_sel]=1.
- While out_valid=1 and no xfer: out_data and out_sel are stable, and in_ready=0.
- en_mask changes while holding: the held word stays on its assigned out_sel, even if that channel is now disabled. en_mask affects only future picks.
- en_mask=0: in_ready=0 and nothing is accepted. A held word can still drain.
- ch_ready bits of channels other than out_sel are ignored.
- xfer_cnt increments by 1 on each xfer and saturates at 2^CNT_W-1 (no wrap).
- in_data and ch_ready are ignored when the related handshake is inactive.
- Reset asserted mid-operation: the held word is discarded immediately (asynchronous), all state returns to reset values, and ptr restarts at 0.
- No combinational path from in_valid or in_data to out_*. in_ready depends only on registered state, en_mask and ch_ready.

Test Plan:
1. Reset then stream: en_mask=1111, ch_ready=1111, in_valid=1 with data 1,0,1,1,0 on consecutive cycles.
   -> out_sel sequence 0,1,2,3,0, one cycle behind input; in_ready stays 1; xfer_cnt=5 after the last transfer.
2. Skip disabled channels: en_mask=1010, ch_ready=1111, four words.
   -> out_sel 1,3,1,3; channels 0 and 2 are never selected.
3. Backpressure: word 1 to channel 0 with ch_ready[0]=0 for 3 cycles, ch_ready[1..3]=1.
   -> out_valid=1, out_sel=0, out_data=1 held for 3 cycles; in_ready=0 throughout; on ch_ready[0]=1 the next word is accepted in the same cycle and presented with out_sel=1.
4. Mask change mid-hold and empty mask: hold a word on channel 2, then set en_mask=0000.
   -> word still drains on channel 2 when ch_ready[2]=1; afterwards in_ready=0 and out_valid=0; restoring en_mask=0001 gives out_sel=0 for the next word (ptr was 3, wraps to 0).
5. Reset mid-transfer and counter saturation:
   - Assert rst_n=0 asynchronously while out_valid=1 -> all outputs 0 immediately; after release, the first word goes to out_sel=0.
   - With CNT_W=3, run 10 transfers -> xfer_cnt stops at 7.
